fetch_sequencer: RTL and testbench

Sequential fetch controller that owns the program counter driving `instruction_memory` in the single-cycle RISC-V core. It steps the PC through instruction memory, applies branch/jump redirects, and holds on stall. It stops cleanly on a halt instruction or on an illegal fetch address, and counts issued instructions. It sits between `instruction_memory` (combinational `pc` to `instruction`) and the decode/execute datapath.

---
 rtl/fetch_sequencer_pkg.sv | 20 ++
 rtl/fetch_sequencer_addr_check.sv | 27 ++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch sequencer and its address checker:
//   - fetch_state_e      : fetch FSM states (IDLE, RUN, HALT, FAULT)
//   - PC_STEP            : byte increment between sequential instructions
//   - HALT_INSN_DEFAULT  : default encoding that ends execution (ECALL)
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_0073;

endpackage : fetch_pkg

// File: rtl/fetch_sequencer_addr_check.sv
// -----------------------------------------------------------------------------
// fetch_addr_check
// Combinational legality check of a byte address against a word-organised
// memory of IMEM_DEPTH 32-bit words. Shared with the data-memory path.
//
// Ports:
//   i_addr  : in,  32 : candidate byte address
//   o_legal : out, 1  : address is word aligned and inside the memory
// -----------------------------------------------------------------------------
module fetch_addr_check #(
  parameter int IMEM_DEPTH = 64
) (
  input  logic [31:0] i_addr,
  output logic        o_legal
);

  // Limit is held in 33 bits so a depth of 2^30 words does not wrap to zero.
  localparam logic [32:0] ADDR_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

  logic w_aligned;
  logic w_in_range;

  assign w_aligned  = (i_addr[1:0] == 2'b00);
  assign w_in_range = ({1'b0, i_addr} < ADDR_LIMIT);
  assign o_legal    = w_aligned && w_in_range;

endmodule : fetch_addr_check

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter of the single-cycle core. Steps the PC through
// instruction memory, applies branch/jump redirects, holds on stall, stops on
// the halt instruction or an illegal next fetch address, and counts issued
// instructions.
//
// Ports:
//   clk             : in,  1  : clock
//   reset           : in,  1  : asynchronous active-high reset
//   start           : in,  1  : begin (IDLE) or restart (HALT/FAULT) fetching
//   stall           : in,  1  : datapath cannot accept an instruction
//   redirect_valid  : in,  1  : issued instruction is a taken branch/jump
//   redirect_target : in,  32 : byte address of the branch/jump target
//   instruction     : in,  32 : word returned by instruction memory for pc
//   pc              : out, 32 : registered fetch address
//   insn_out        : out, 32 : instruction forwarded to decode
//   insn_valid      : out, 1  : insn_out is issued this cycle
//   halted          : out, 1  : FSM is in HALT
//   fault           : out, 1  : FSM is in FAULT
//   issue_count     : out, 32 : instructions issued since reset/restart
//   dbg_state       : out, 2  : current FSM state, for observation only
//
// Handshake: insn_valid is the issue strobe and stall is the inverse of the
// datapath's ready. insn_valid is never raised while stall is high, so an
// instruction transfers in exactly the cycles where insn_valid=1; there is no
// separate ready term for the consumer to combine.
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] HALT_INSN  = HALT_INSN_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_target,
  input  logic [31:0]  instruction,
  output logic [31:0]  pc,
  output logic [31:0]  insn_out,
  output logic         insn_valid,
  output logic         halted,
  output logic         fault,
  output logic [31:0]  issue_count,
  output fetch_state_e dbg_state
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_next_pc;
  logic [31:0]  r_issue_count;
  logic [31:0]  w_next_count;
  logic [31:0]  w_cand_pc;
  logic         w_cand_legal;
  logic         w_insn_valid;

  // Candidate next PC if the current instruction issues.
  assign w_cand_pc = redirect_valid ? redirect_target : (r_pc + PC_STEP);

  fetch_addr_check #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_addr_check (
    .i_addr  (w_cand_pc),
    .o_legal (w_cand_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_issue_count <= 32'd0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_next_pc;
      r_issue_count <= w_next_count;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_count = r_issue_count;
    w_insn_valid = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_RUN;
        end
      end

      ST_RUN: begin
        // Stall wins over everything, including a pending redirect.
        if (stall) begin
          w_next_state = ST_RUN;
        end else if (instruction == HALT_INSN) begin
          // Halt is not issued and any concurrent redirect is dropped.
          w_next_state = ST_HALT;
        end else begin
          // The instruction issues even when the address it leads to is
          // illegal; only the following fetch is suppressed.
          w_insn_valid = 1'b1;
          w_next_count = r_issue_count + 32'd1;
          if (w_cand_legal) begin
            w_next_pc = w_cand_pc;
          end else begin
            w_next_state = ST_FAULT;
          end
        end
      end

      ST_HALT, ST_FAULT: begin
        if (start) begin
          w_next_state = ST_RUN;
          w_next_pc    = RESET_PC;
          w_next_count = 32'd0;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign pc          = r_pc;
  assign insn_out    = instruction;
  assign insn_valid  = w_insn_valid;
  assign halted      = (r_state == ST_HALT);
  assign fault       = (r_state == ST_FAULT);
  assign issue_count = r_issue_count;
  assign dbg_state   = r_state;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Drives the fetch sequencer with directed scenarios followed by randomized
// stall/redirect/start traffic. A behavioural instruction memory answers the
// DUT's pc. A reference model, advanced once per driven cycle, pushes the
// expected per-cycle outputs into exp_q; an independent monitor pops and
// compares them a few ns after each falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] HALT  = 32'h0000_0073;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_target = 32'd0;
  logic [31:0]  instruction;
  logic [31:0]  pc;
  logic [31:0]  insn_out;
  logic         insn_valid;
  logic         halted;
  logic         fault;
  logic [31:0]  issue_count;
  fetch_state_e dbg_state;

  logic [31:0] imem [DEPTH];

  // Behavioural instruction memory: combinational word read at pc.
  assign instruction = imem[pc[7:2]];

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instruction     (instruction),
    .pc              (pc),
    .insn_out        (insn_out),
    .insn_valid      (insn_valid),
    .halted          (halted),
    .fault           (fault),
    .issue_count     (issue_count),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] ins;
    logic        halted;
    logic        fault;
    logic [31:0] cnt;
    logic [1:0]  st;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  fetch_state_e m_mode = ST_IDLE;
  logic [31:0]  m_pc   = 32'd0;
  logic [31:0]  m_cnt  = 32'd0;

  function automatic bit legal_addr(input longint a);
    return (a % 4 == 0) && (a >= 0) && (a < DEPTH * 4);
  endfunction

  task automatic model_reset();
    m_mode = ST_IDLE;
    m_pc   = 32'd0;
    m_cnt  = 32'd0;
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs at the falling edge, records what the DUT
  // must show during that cycle, then advances the model past the next
  // rising edge.
  task automatic drive(input bit st, input bit stl, input bit rv, input logic [31:0] rt);
    snap_t  s;
    longint tgt;
    logic [31:0] ins;
    @(negedge clk);
    start           = st;
    stall           = stl;
    redirect_valid  = rv;
    redirect_target = rt;

    ins      = imem[m_pc / 4];
    s.pc     = m_pc;
    s.ins    = ins;
    s.valid  = (m_mode == ST_RUN) && !stl && (ins != HALT);
    s.halted = (m_mode == ST_HALT);
    s.fault  = (m_mode == ST_FAULT);
    s.cnt    = m_cnt;
    s.st     = m_mode;
    exp_q.push_back(s);

    case (m_mode)
      ST_IDLE: if (st) m_mode = ST_RUN;
      ST_RUN: begin
        if (!stl) begin
          if (ins == HALT) begin
            m_mode = ST_HALT;
          end else begin
            m_cnt = m_cnt + 1;
            tgt = rv ? longint'(rt) : longint'(m_pc) + 4;
            if (legal_addr(tgt)) m_pc = tgt[31:0];
            else m_mode = ST_FAULT;
          end
        end
      end
      default: begin
        if (st) begin
          m_mode = ST_RUN;
          m_pc   = 32'd0;
          m_cnt  = 32'd0;
        end
      end
    endcase
  endtask

  // ---------------- monitor ----------------
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",          pc,                   e.pc);
        check("insn_valid",  {31'd0, insn_valid},  {31'd0, e.valid});
        check("insn_out",    insn_out,             e.ins);
        check("halted",      {31'd0, halted},      {31'd0, e.halted});
        check("fault",       {31'd0, fault},       {31'd0, e.fault});
        check("issue_count", issue_count,          e.cnt);
        check("state",       {30'd0, dbg_state},   {30'd0, e.st});
      end
    end
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0000_0013;
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] tgt;
    int          sel;

    for (int i = 0; i < DEPTH; i++) imem[i] = rand_word();
    imem[8] = HALT;  // halt at byte address 0x20

    // Reset state, checked while reset is held.
    #3;
    check("rst_pc",     pc,                  32'd0);
    check("rst_valid",  {31'd0, insn_valid}, 32'd0);
    check("rst_halted", {31'd0, halted},     32'd0);
    check("rst_fault",  {31'd0, fault},      32'd0);
    check("rst_count",  issue_count,         32'd0);
    check("rst_state",  {30'd0, dbg_state},  {30'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b0;

    // Start, then sequential 0x0, 0x4.
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    // Two stall cycles at 0x8; the redirect during stall must be ignored.
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 32'h40);
    // 0x8, 0xC, 0x10, then redirect at 0x14 back to 0x8.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    drive(0, 0, 1, 32'h8);
    // 0x8 .. 0x18, then redirect at 0x1C to the halt at 0x20.
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
    drive(0, 0, 1, 32'h20);
    // Halt with a concurrent redirect: halt wins.
    drive(0, 0, 1, 32'h4);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    // Restart from HALT, run to 0x10.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);

    // Asynchronous reset between edges while running at 0x10.
    #5;
    reset = 1'b1;
    #2;
    check("async_pc",    pc,                  32'd0);
    check("async_state", {30'd0, dbg_state},  {30'd0, ST_IDLE});
    check("async_valid", {31'd0, insn_valid}, 32'd0);
    check("async_count", issue_count,         32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // No fetch without start.
    drive(0, 0, 0, 0);
    drive(0, 1, 1, 32'h8);
    // Misaligned redirect fault.
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 32'h6);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    // Out-of-range redirect fault (exactly IMEM_DEPTH*4).
    drive(1, 0, 0, 0);
    drive(0, 0, 1, DEPTH * 4);
    drive(0, 0, 0, 0);
    // Sequential fall-off past the last word.
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 32'hF8);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Randomized phase: new memory image with sparse halts.
    #5;
    for (int i = 0; i < DEPTH; i++)
      imem[i] = ($urandom_range(0, 99) < 4) ? HALT : rand_word();
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 70)      tgt = $urandom_range(0, DEPTH - 1) * 4;
      else if (sel < 85) tgt = $urandom_range(0, DEPTH * 4 - 1);
      else               tgt = (sel < 92) ? $urandom_range(DEPTH * 4, DEPTH * 4 + 64) : $urandom;
      drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 20, tgt);
    end

    // Let the monitor drain the final expectation.
    @(negedge clk);
    #5;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_fetch_sequencer
